// File: rtl/snoop_bcast_merge.sv
// ACE snoop fan-out/fan-in: broadcasts one AC request to the enabled cached
// masters, merges their CR responses and returns a single response upstream.
module snoop_bcast_merge #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumPorts-1:0]   port_en_i,
  input  logic                  ac_valid_i,
  output logic                  ac_ready_o,
  input  logic [AddrWidth-1:0]  ac_addr_i,
  input  logic [3:0]            ac_snoop_i,
  input  logic [2:0]            ac_prot_i,
  output logic [NumPorts-1:0]   ac_valid_o,
  input  logic [NumPorts-1:0]   ac_ready_i,
  output logic [AddrWidth-1:0]  ac_addr_o,
  output logic [3:0]            ac_snoop_o,
  output logic [2:0]            ac_prot_o,
  input  logic [NumPorts-1:0]   cr_valid_i,
  output logic [NumPorts-1:0]   cr_ready_o,
  input  logic [NumPorts*5-1:0] cr_resp_i,
  output logic                  cr_valid_o,
  input  logic                  cr_ready_i,
  output logic [4:0]            cr_resp_o,
  output logic [IdxWidth-1:0]   cr_src_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT                 state;
  logic [NumPorts-1:0]   acPend;
  logic [NumPorts-1:0]   crPend;
  logic [AddrWidth-1:0]  addrQ;
  logic [3:0]            snoopQ;
  logic [2:0]            protQ;
  logic [4:0]            mergedResp;
  logic [IdxWidth-1:0]   srcIdx;
  logic                  srcFound;

  logic [NumPorts-1:0]   acFire;
  logic [NumPorts-1:0]   crFire;
  logic [NumPorts-1:0]   acPendNxt;
  logic [NumPorts-1:0]   crPendNxt;
  logic [4:0]            respOr;
  logic                  dirtyAny;
  logic                  dirtyMulti;
  logic                  dirtyErr;
  logic                  dataHit;
  logic [IdxWidth-1:0]   dataIdx;

  function automatic logic isReserved(input logic [3:0] snoop);
    case (snoop)
      4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1100: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  assign ac_ready_o = (state == IDLE);
  assign ac_valid_o = acPend;
  assign cr_ready_o = crPend & ~acPend;
  assign cr_valid_o = (state == RESP);
  assign cr_resp_o  = mergedResp;
  assign cr_src_o   = srcIdx;
  assign ac_addr_o  = addrQ;
  assign ac_snoop_o = snoopQ;
  assign ac_prot_o  = protQ;

  // A second passDirty, whether in this cycle or on top of an earlier one,
  // is a coherence violation and raises the merged error bit.
  always_comb begin
    acFire     = acPend & ac_ready_i;
    crFire     = crPend & ~acPend & cr_valid_i;
    acPendNxt  = acPend & ~acFire;
    crPendNxt  = crPend & ~crFire;
    respOr     = '0;
    dirtyAny   = 1'b0;
    dirtyMulti = 1'b0;
    dataHit    = 1'b0;
    dataIdx    = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (crFire[i]) begin
        respOr = respOr | cr_resp_i[5*i +: 5];
        if (cr_resp_i[5*i+2]) begin
          dirtyMulti = dirtyMulti | dirtyAny;
          dirtyAny   = 1'b1;
        end
        if (cr_resp_i[5*i] && !dataHit) begin
          dataHit = 1'b1;
          dataIdx = IdxWidth'(i);
        end
      end
    end
    dirtyErr = dirtyMulti | (dirtyAny & mergedResp[2]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      acPend     <= '0;
      crPend     <= '0;
      addrQ      <= '0;
      snoopQ     <= '0;
      protQ      <= '0;
      mergedResp <= '0;
      srcIdx     <= '0;
      srcFound   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ac_valid_i) begin
            addrQ    <= ac_addr_i;
            snoopQ   <= ac_snoop_i;
            protQ    <= ac_prot_i;
            srcIdx   <= '0;
            srcFound <= 1'b0;
            if (isReserved(ac_snoop_i)) begin
              acPend     <= '0;
              crPend     <= '0;
              mergedResp <= 5'b00010;
              state      <= RESP;
            end else begin
              acPend     <= port_en_i;
              crPend     <= port_en_i;
              mergedResp <= '0;
              state      <= (port_en_i == '0) ? RESP : BUSY;
            end
          end
        end
        BUSY: begin
          acPend     <= acPendNxt;
          crPend     <= crPendNxt;
          mergedResp <= mergedResp | respOr | {3'b000, dirtyErr, 1'b0};
          if (dataHit && !srcFound) begin
            srcIdx   <= dataIdx;
            srcFound <= 1'b1;
          end
          if (acPendNxt == '0 && crPendNxt == '0) state <= RESP;
        end
        RESP: begin
          if (cr_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
